// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
// Holds the FSM state encoding and the default macro geometry.
package sram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int STRB_W = 4;

    localparam logic [STRB_W-1:0] WEB_IDLE = 4'hF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: the first set request found searching
// upward from ptr+1, wrapping modulo N.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin : pick
        logic [IDX_W-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Burst-granular round-robin arbiter in front of a synchronous single-port
// SRAM macro with byte write enables and a fixed 1-cycle read latency.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          wbeat_ack,
    output logic [NUM_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_last,
    output logic [NUM_REQ-1:0]          wr_done,
    output logic [ADDR_W-1:0]           sram_a,
    output logic [STRB_W-1:0]           sram_web,
    output logic [DATA_W-1:0]           sram_di,
    input  logic [DATA_W-1:0]           sram_do
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   ptr;
    logic [ADDR_W-1:0]  base;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   cnt;
    logic               is_write;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [NUM_REQ-1:0] owner_oh;
    logic               last_beat;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (win_oh),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign owner_oh  = NUM_REQ'(1) << owner;
    assign last_beat = (cnt == len);
    assign rd_data   = sram_do;

    // Grants are only offered in IDLE; the reset gate keeps req_ready low
    // while rst_n is asserted even if a requester is already waiting.
    always_comb begin
        req_ready = '0;
        wbeat_ack = '0;
        sram_a    = '0;
        sram_web  = WEB_IDLE;
        sram_di   = '0;
        if (state == IDLE) begin
            if (rst_n) begin
                req_ready = win_oh;
            end
        end else begin
            sram_a = base + ADDR_W'(cnt);
            if (is_write) begin
                sram_web  = ~req_wstrb[owner*STRB_W +: STRB_W];
                sram_di   = req_wdata[owner*DATA_W +: DATA_W];
                wbeat_ack = owner_oh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= IDX_W'(NUM_REQ - 1);
            base     <= '0;
            len      <= '0;
            cnt      <= '0;
            is_write <= 1'b0;
            rd_valid <= '0;
            rd_last  <= 1'b0;
            wr_done  <= '0;
        end else begin
            rd_valid <= '0;
            rd_last  <= 1'b0;
            wr_done  <= '0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        owner    <= win_idx;
                        ptr      <= win_idx;
                        base     <= req_addr[win_idx*ADDR_W +: ADDR_W];
                        len      <= req_len[win_idx*LEN_W +: LEN_W];
                        is_write <= req_write[win_idx];
                        cnt      <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    cnt <= cnt + 1'b1;
                    if (!is_write) begin
                        rd_valid <= owner_oh;
                    end
                    if (last_beat) begin
                        state <= IDLE;
                        if (is_write) begin
                            wr_done <= owner_oh;
                        end else begin
                            rd_last <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
